// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide single-port RAM between instruction fetch and load/store traffic.
// Optional build macro MEM_ARB_FAST_WRITE_EN: stores raise mem_done_o on their last byte and skip DONE.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [2:0]        mem_len_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   output logic              stallreq_o
);
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic              owner_mem_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        len_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       if_data_reg;
   logic [31:0]       mem_rdata_reg;

   logic              grant, grant_mem, if_abort, capture, last_wr;
   logic [2:0]        mem_len_dec;
   logic [1:0]        byte_idx;
   logic [7:0]        wdata_byte [4];

   always_comb begin
      case (mem_len_i)
         3'd1, 3'd2: mem_len_dec = mem_len_i;
         default:    mem_len_dec = 3'd4;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wbyte
         assign wdata_byte[gi] = wdata_reg[8*gi +: 8];
      end
   endgenerate

   // A fetch is dropped as soon as the pc moves on or the request is withdrawn.
   assign if_abort = (state_reg == S_RD) && !owner_mem_reg &&
                     (!if_req_i || (if_addr_i != addr_reg));
   assign last_wr  = (state_reg == S_WR) && (cnt_reg == len_reg - 3'd1);
   // RAM read latency is one cycle, so the byte seen at cnt belongs to address cnt-1.
   assign capture  = (state_reg == S_RD) && (cnt_reg != 3'd0) && !if_abort;
   assign byte_idx = 2'(cnt_reg - 3'd1);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      grant      = 1'b0;
      grant_mem  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            cnt_next = 3'd0;
            if (mem_req_i) begin
               grant      = 1'b1;
               grant_mem  = 1'b1;
               state_next = mem_we_i ? S_WR : S_RD;
            end else if (if_req_i) begin
               grant      = 1'b1;
               state_next = S_RD;
            end
         end
         S_RD: begin
            if (if_abort) begin
               state_next = S_IDLE;
               cnt_next   = 3'd0;
            end else if (cnt_reg == len_reg) begin
               state_next = S_DONE;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         S_WR: begin
            if (last_wr) begin
`ifdef MEM_ARB_FAST_WRITE_EN
               state_next = S_IDLE;
`else
               state_next = S_DONE;
`endif
               cnt_next = 3'd0;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= 3'd0;
         owner_mem_reg <= 1'b0;
         addr_reg      <= '0;
         len_reg       <= 3'd0;
         wdata_reg     <= 32'h0;
         if_data_reg   <= 32'h0;
         mem_rdata_reg <= 32'h0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (grant) begin
            owner_mem_reg <= grant_mem;
            addr_reg      <= grant_mem ? mem_addr_i : if_addr_i;
            len_reg       <= grant_mem ? mem_len_dec : 3'd4;
            wdata_reg     <= mem_wdata_i;
            // Cleared here so bytes beyond len read back as zero.
            if (grant_mem)
               mem_rdata_reg <= 32'h0;
            else
               if_data_reg <= 32'h0;
         end
         if (capture) begin
            if (owner_mem_reg)
               mem_rdata_reg[{byte_idx, 3'b000} +: 8] <= ram_din_i;
            else
               if_data_reg[{byte_idx, 3'b000} +: 8] <= ram_din_i;
         end
      end
   end

   assign ram_addr_o = ((state_reg == S_RD) || (state_reg == S_WR)) ?
                       addr_reg + ADDR_W'(cnt_reg) : '0;
   assign ram_we_o   = (state_reg == S_WR);
   assign ram_dout_o = ram_we_o ? wdata_byte[cnt_reg[1:0]] : 8'h00;

   assign if_done_o  = (state_reg == S_DONE) && !owner_mem_reg;
`ifdef MEM_ARB_FAST_WRITE_EN
   assign mem_done_o = ((state_reg == S_DONE) && owner_mem_reg) || last_wr;
`else
   assign mem_done_o = (state_reg == S_DONE) && owner_mem_reg;
`endif

   assign if_data_o   = if_data_reg;
   assign mem_rdata_o = mem_rdata_reg;
   assign stallreq_o  = (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions against a byte RAM model plus directed corner-case sequences.
module tb_mem_arbiter;
   localparam int ADDR_W = 32;
`ifdef MEM_ARB_FAST_WRITE_EN
   localparam int FW = 1;
`else
   localparam int FW = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [31:0]       if_data_o;
   logic              if_done_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [2:0]        mem_len_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic [31:0]       mem_rdata_o;
   logic              mem_done_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_we_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ram_din_i;
   logic              stallreq_o;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
      .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
      .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   // Byte RAM model (64 KiB window), one-cycle read latency, with a preload port.
   bit   [7:0]  ram [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_a  = 16'h0;
   logic [7:0]  pl_d  = 8'h0;
   always @(posedge clk) begin
      ram_din_i <= ram[ram_addr_o[15:0]];
      if (pl_en)
         ram[pl_a] <= pl_d;
      else if (ram_we_o)
         ram[ram_addr_o[15:0]] <= ram_dout_o;
   end

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;
   wr_t wlog[$];
   always @(negedge clk) if (ram_we_o) wlog.push_back('{ram_addr_o, ram_dout_o});

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [2:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;
   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      chk({tag, "_ram_addr"}, ram_addr_o, 32'h0);
      chk({tag, "_ram_we"}, 32'(ram_we_o), 32'h0);
      chk({tag, "_ram_dout"}, 32'(ram_dout_o), 32'h0);
      chk({tag, "_if_data"}, if_data_o, 32'h0);
      chk({tag, "_mem_rdata"}, mem_rdata_o, 32'h0);
      chk({tag, "_if_done"}, 32'(if_done_o), 32'h0);
      chk({tag, "_mem_done"}, 32'(mem_done_o), 32'h0);
      chk({tag, "_stallreq"}, 32'(stallreq_o), 32'h0);
   endtask

   // Called just after a rising edge; cycle 1 is the IDLE cycle that samples the request.
   task automatic run_txn(input logic is_mem, input logic we, input logic [2:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] data, output logic other);
      lat   = 0;
      data  = 32'h0;
      other = 1'b0;
      if (is_mem) begin
         mem_req_i   = 1'b1;
         mem_we_i    = we;
         mem_len_i   = len;
         mem_addr_i  = addr;
         mem_wdata_i = wdata;
      end else begin
         if_req_i  = 1'b1;
         if_addr_i = addr;
      end
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (is_mem ? if_done_o : mem_done_o) other = 1'b1;
         if (is_mem ? mem_done_o : if_done_o) begin
            lat  = n;
            data = is_mem ? mem_rdata_o : if_data_o;
            break;
         end
         tick();
      end
      tick();
      mem_req_i = 1'b0;
      if_req_i  = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, md, id;
      logic [31:0] data, mdata, idata;
      logic        other;
      vec_t        v;
      logic [31:0] wa [4];
      logic [7:0]  wd [4];

      vecs[0]  = '{1'b0, 1'b0, 3'd4, 32'h0000_0100, 32'h0,         32'h0000_0513, 7};
      vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0000_2001, 32'h0,         32'h0000_BBAA, 5};
      vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0,         32'h0000_00BB, 4};
      vecs[3]  = '{1'b1, 1'b0, 3'd4, 32'h0000_3000, 32'h0,         32'h4433_2211, 7};
      vecs[4]  = '{1'b1, 1'b0, 3'd3, 32'h0000_3000, 32'h0,         32'h4433_2211, 7};
      vecs[5]  = '{1'b1, 1'b1, 3'd1, 32'h0000_0030, 32'h1234_5678, 32'h0,         3 - FW};
      vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0030, 32'h0,         32'h0000_0078, 7};
      vecs[7]  = '{1'b1, 1'b1, 3'd2, 32'h0000_0041, 32'hCAFE_BEEF, 32'h0,         4 - FW};
      vecs[8]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0040, 32'h0,         32'h00BE_EF00, 7};
      vecs[9]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0050, 32'h89AB_CDEF, 32'h0,         6 - FW};
      vecs[10] = '{1'b1, 1'b0, 3'd4, 32'h0000_0050, 32'h0,         32'h89AB_CDEF, 7};
      vecs[11] = '{1'b1, 1'b0, 3'd2, 32'h0000_0052, 32'h0,         32'h0000_89AB, 5};

      rst = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 3'd0; mem_addr_i = '0; mem_wdata_i = 32'h0;
      tick();
      preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
      preload(16'h0200, 8'h93); preload(16'h0202, 8'h10);
      preload(16'h2001, 8'hAA); preload(16'h2002, 8'hBB);
      preload(16'h3000, 8'h11); preload(16'h3001, 8'h22);
      preload(16'h3002, 8'h33); preload(16'h3003, 8'h44);
      check_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Fetch and load requested together: load wins, fetch follows.
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 3'd2; mem_addr_i = 32'h2001;
      if_req_i  = 1'b1; if_addr_i = 32'h100;
      md = 0; id = 0; mdata = 32'h0; idata = 32'h0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (mem_done_o && md == 0) begin md = n; mdata = mem_rdata_o; end
         if (if_done_o && id == 0) begin id = n; idata = if_data_o; end
         if (id != 0) break;
         tick();
         if (md != 0) mem_req_i = 1'b0;
      end
      $display("txn both: mem_done cycle=%0d data=%h if_done cycle=%0d data=%h", md, mdata, id, idata);
      chk("both_mem_cycle", 32'(md), 32'd5);
      chk("both_mem_data", mdata, 32'h0000_BBAA);
      chk("both_if_cycle", 32'(id), 32'd12);
      chk("both_if_data", idata, 32'h0000_0513);
      tick();
      mem_req_i = 1'b0; if_req_i = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         v = vecs[i];
         run_txn(v.is_mem, v.we, v.len, v.addr, v.wdata, lat, data, other);
         $display("txn %0d: mem=%0d we=%0d len=%0d addr=%h lat=%0d data=%h", i, v.is_mem, v.we,
                  v.len, v.addr, lat, data);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
         chk($sformatf("vec%0d_other_done", i), 32'(other), 32'h0);
         if (!v.we) chk($sformatf("vec%0d_data", i), data, v.exp_data);
      end

      // Single-byte store: one write strobe with the low byte.
      wlog.delete();
      run_txn(1'b1, 1'b1, 3'd1, 32'h30, 32'h1234_5678, lat, data, other);
      $display("txn store1: lat=%0d writes=%0d", lat, wlog.size());
      chk("store1_latency", 32'(lat), 32'(3 - FW));
      chk("store1_nwrites", 32'(wlog.size()), 32'd1);
      if (wlog.size() == 1) begin
         chk("store1_addr", wlog[0].a, 32'h30);
         chk("store1_byte", 32'(wlog[0].d), 32'h78);
      end

      // Fetch abandoned at cnt=2 by a pc change, then refetched at the new address.
      wlog.delete();
      if_req_i = 1'b1; if_addr_i = 32'h100;
      id = 0; idata = 32'h0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (n == 6) chk("abort_refetch_addr", ram_addr_o, 32'h200);
         if (if_done_o) begin id = n; idata = if_data_o; break; end
         tick();
         if (n == 3) if_addr_i = 32'h200;
      end
      tick();
      if_req_i = 1'b0;
      tick();
      $display("txn abort: if_done cycle=%0d data=%h writes=%0d", id, idata, wlog.size());
      chk("abort_done_cycle", 32'(id), 32'd11);
      chk("abort_data", idata, 32'h0010_0093);
      chk("abort_no_writes", 32'(wlog.size()), 32'd0);

      // Word store wrapping past the top of the address space, with stall tracking.
      wlog.delete();
      wa[0] = 32'hFFFF_FFFE; wa[1] = 32'hFFFF_FFFF; wa[2] = 32'h0; wa[3] = 32'h1;
      wd[0] = 8'hD4; wd[1] = 8'hC3; wd[2] = 8'hB2; wd[3] = 8'hA1;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 3'd4;
      mem_addr_i = 32'hFFFF_FFFE; mem_wdata_i = 32'hA1B2_C3D4;
      md = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_done_o) begin
            md = n;
            chk("wrap_stall_at_done", 32'(stallreq_o), 32'h0);
            break;
         end
         chk($sformatf("wrap_stall_c%0d", n), 32'(stallreq_o), 32'h1);
         tick();
      end
      tick();
      mem_req_i = 1'b0;
      tick();
      $display("txn wrapstore: lat=%0d writes=%0d", md, wlog.size());
      chk("wrap_latency", 32'(md), 32'(6 - FW));
      chk("wrap_nwrites", 32'(wlog.size()), 32'd4);
      if (wlog.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap_addr%0d", k), wlog[k].a, wa[k]);
            chk($sformatf("wrap_byte%0d", k), 32'(wlog[k].d), 32'(wd[k]));
         end
      end
      run_txn(1'b1, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0, lat, data, other);
      $display("txn wrapload: lat=%0d data=%h", lat, data);
      chk("wrapload_latency", 32'(lat), 32'd7);
      chk("wrapload_data", data, 32'hA1B2_C3D4);

      // Reset held two cycles in the middle of a fetch.
      if_req_i = 1'b1; if_addr_i = 32'h100;
      tick();
      tick();
      rst = 1'b1; if_req_i = 1'b0;
      tick();
      check_zero("midrst");
      tick();
      rst = 1'b0;
      tick();
      run_txn(1'b0, 1'b0, 3'd4, 32'h100, 32'h0, lat, data, other);
      $display("txn post_reset_fetch: lat=%0d data=%h", lat, data);
      chk("postrst_latency", 32'(lat), 32'd7);
      chk("postrst_data", data, 32'h0000_0513);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
